// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch state encoding, word constants and
// the word-align helper also used by the EX/MEM address logic.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } fetch_state_e;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] x);
    return {x[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: hazard-unit and ID-stage controls in, PC, IMEM address and
// status flags out. The fetch unit uses the master side.
interface if_fetch_unit_if #(
  parameter int IMEM_AW = 9
);
  logic               LE;
  logic               BR_TAKEN;
  logic [31:0]        TA;
  logic [31:0]        PC;
  logic [31:0]        NPC;
  logic [IMEM_AW-1:0] IMEM_ADDR;
  logic               IF_LE;
  logic               PEND;
  logic               TA_MISALIGN;

  modport master (
    input  LE, BR_TAKEN, TA,
    output PC, NPC, IMEM_ADDR, IF_LE, PEND, TA_MISALIGN
  );

  modport slave (
    output LE, BR_TAKEN, TA,
    input  PC, NPC, IMEM_ADDR, IF_LE, PEND, TA_MISALIGN
  );
endinterface

// File: rtl/fetch_fsm.sv
// Fetch sequencing: BOOT/RUN/PEND state, the pending branch target held across
// a stall, and the sticky misaligned-target flag.
//   state   | meaning
//   ST_BOOT | one idle cycle after reset release, PC/NPC hold, IF/ID not loaded
//   ST_RUN  | normal fetch; advances or redirects when LE=1
//   ST_PEND | taken target latched during a stall, applied on the first LE=1
module fetch_fsm
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        le_i,
  input  logic        br_taken_i,
  input  logic [31:0] ta_i,
  output logic        if_le_o,
  output logic        pend_o,
  output logic        load_tgt_o,
  output logic        advance_o,
  output logic [31:0] tgt_o,
  output logic        misalign_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  ta_aligned;

  assign ta_aligned = align_word(ta_i);
  assign misalign_o = misalign_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_BOOT;
      pend_tgt_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    misalign_d = misalign_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!le_i && br_taken_i) begin
          state_d    = ST_PEND;
          pend_tgt_d = ta_aligned;
        end
      end
      ST_PEND: begin
        // a newer taken branch during the stall replaces the older target
        if (le_i) state_d = ST_RUN;
        else if (br_taken_i) pend_tgt_d = ta_aligned;
      end
      default: state_d = ST_BOOT;
    endcase
    if (state_q != ST_BOOT && br_taken_i && ta_i[1:0] != 2'b00) misalign_d = 1'b1;
  end

  always_comb begin
    if_le_o    = 1'b0;
    pend_o     = 1'b0;
    load_tgt_o = 1'b0;
    advance_o  = 1'b0;
    tgt_o      = ta_aligned;
    unique case (state_q)
      ST_RUN: begin
        if_le_o    = le_i;
        load_tgt_o = le_i & br_taken_i;
        advance_o  = le_i & ~br_taken_i;
      end
      ST_PEND: begin
        if_le_o    = le_i;
        pend_o     = 1'b1;
        load_tgt_o = le_i;
        if (!br_taken_i) tgt_o = pend_tgt_q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns PC/NPC, drives the IMEM address and the
// IF/ID load enable, and redirects to ID-resolved targets after the delay slot.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 9
) (
  input  logic            Clk,
  input  logic            Reset,
  if_fetch_unit_if.master bus
);

  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic        load_tgt, advance;
  logic [31:0] tgt;

  fetch_fsm u_fsm (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .le_i       (bus.LE),
    .br_taken_i (bus.BR_TAKEN),
    .ta_i       (bus.TA),
    .if_le_o    (bus.IF_LE),
    .pend_o     (bus.PEND),
    .load_tgt_o (load_tgt),
    .advance_o  (advance),
    .tgt_o      (tgt),
    .misalign_o (bus.TA_MISALIGN)
  );

  // PC math wraps modulo 2^32
  always_comb begin
    pc_d  = pc_q;
    npc_d = npc_q;
    if (load_tgt) begin
      pc_d  = tgt;
      npc_d = tgt + STEP;
    end else if (advance) begin
      pc_d  = npc_q;
      npc_d = npc_q + STEP;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_q  <= RESET_PC;
      npc_q <= RESET_PC + STEP;
    end else begin
      pc_q  <= pc_d;
      npc_q <= npc_d;
    end
  end

  assign bus.PC        = pc_q;
  assign bus.NPC       = npc_q;
  assign bus.IMEM_ADDR = pc_q[IMEM_AW-1:0];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table for the fetch scenarios, then
// randomized traffic checked against a queue-based reference model.
module tb_if_fetch_unit;

  localparam int          AW  = 9;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  if_fetch_unit_if #(.IMEM_AW(AW)) bus ();

  if_fetch_unit #(.RESET_PC(RPC), .IMEM_AW(AW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        le;
    logic        br;
    logic [31:0] ta;
    logic        if_le;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        pend;
    logic        mis;
  } vec_t;

  vec_t vt[$];
  int total = 0;
  int bad   = 0;

  // reference model: PC/NPC, boot flag, pending targets as a 0/1-entry queue
  logic        m_boot;
  logic [31:0] m_pc, m_npc;
  logic [31:0] m_q[$];
  logic        m_mis;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void add(logic r, logic l, logic b, logic [31:0] t,
                              logic il, logic [31:0] p, logic [31:0] n,
                              logic pd, logic m);
    vt.push_back(vec_t'{r, l, b, t, il, p, n, pd, m});
  endfunction

  task automatic model_edge(input logic r, input logic le, input logic br,
                            input logic [31:0] ta);
    logic [31:0] t;
    if (!r) begin
      m_pc = RPC; m_npc = RPC + 32'd4; m_boot = 1'b1; m_q.delete(); m_mis = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      if (br && ta[1:0] != 2'b00) m_mis = 1'b1;
      if (le) begin
        if (br || m_q.size() != 0) begin
          t = br ? (ta & 32'hFFFF_FFFC) : m_q[0];
          m_pc = t; m_npc = t + 32'd4;
        end else begin
          m_pc = m_npc; m_npc = m_npc + 32'd4;
        end
        m_q.delete();
      end else if (br) begin
        m_q.delete();
        m_q.push_back(ta & 32'hFFFF_FFFC);
      end
    end
  endtask

  task automatic post_checks(string tag, logic [31:0] pc, logic [31:0] npc,
                             logic pend, logic mis);
    logic [31:0] ia;
    ia = pc & 32'h0000_01FF;
    chk({tag, "_pc"}, bus.PC, pc);
    chk({tag, "_npc"}, bus.NPC, npc);
    chk({tag, "_imem"}, 32'(bus.IMEM_ADDR), ia);
    chk({tag, "_pend"}, 32'(bus.PEND), 32'(pend));
    chk({tag, "_mis"}, 32'(bus.TA_MISALIGN), 32'(mis));
  endtask

  initial begin
    // rst le br ta | if_le(pre-edge) pc npc pend mis (post-edge)
    add(0,1,0,32'h0,          0, 32'h0,        32'h4,        0,0);
    add(1,1,0,32'h0,          0, 32'h0,        32'h4,        0,0); // BOOT
    add(1,1,0,32'h0,          1, 32'h4,        32'h8,        0,0);
    add(1,1,0,32'h0,          1, 32'h8,        32'hC,        0,0);
    add(1,1,0,32'h0,          1, 32'hC,        32'h10,       0,0);
    add(1,1,1,32'h40,         1, 32'h40,       32'h44,       0,0); // delay slot 0xC
    add(1,1,0,32'h0,          1, 32'h44,       32'h48,       0,0);
    add(1,0,0,32'h0,          0, 32'h44,       32'h48,       0,0); // stall
    add(1,0,0,32'h0,          0, 32'h44,       32'h48,       0,0);
    add(1,0,0,32'h0,          0, 32'h44,       32'h48,       0,0);
    add(1,1,0,32'h0,          1, 32'h48,       32'h4C,       0,0);
    add(1,0,1,32'h80,         0, 32'h48,       32'h4C,       1,0); // stall + branch
    add(1,0,0,32'h0,          0, 32'h48,       32'h4C,       1,0);
    add(1,0,0,32'h0,          0, 32'h48,       32'h4C,       1,0);
    add(1,1,0,32'h0,          1, 32'h80,       32'h84,       0,0);
    add(1,1,0,32'h0,          1, 32'h84,       32'h88,       0,0);
    add(1,1,1,32'h103,        1, 32'h100,      32'h104,      0,1); // misaligned
    add(1,1,1,32'h200,        1, 32'h200,      32'h204,      0,1);
    add(1,1,0,32'h0,          1, 32'h204,      32'h208,      0,1);
    add(1,0,1,32'h300,        0, 32'h204,      32'h208,      1,1);
    add(1,0,1,32'h400,        0, 32'h204,      32'h208,      1,1);
    add(1,1,1,32'h500,        1, 32'h500,      32'h504,      0,1); // TA beats pending
    add(1,0,1,32'h600,        0, 32'h500,      32'h504,      1,1);
    add(1,0,1,32'h700,        0, 32'h500,      32'h504,      1,1);
    add(1,1,0,32'h0,          1, 32'h700,      32'h704,      0,1); // latest wins
    add(1,1,1,32'hFFFF_FFF8,  1, 32'hFFFF_FFF8,32'hFFFF_FFFC,0,1);
    add(1,1,0,32'h0,          1, 32'hFFFF_FFFC,32'h0,        0,1); // wrap
    add(1,1,0,32'h0,          1, 32'h0,        32'h4,        0,1);
    add(1,1,0,32'h0,          1, 32'h4,        32'h8,        0,1);
    add(1,0,1,32'h900,        0, 32'h4,        32'h8,        1,1);
    add(0,0,0,32'h0,          0, 32'h0,        32'h4,        0,0); // reset in PEND
    add(1,1,1,32'h900,        0, 32'h0,        32'h4,        0,0); // BOOT ignores BR
    add(1,1,0,32'h0,          1, 32'h4,        32'h8,        0,0);

    Reset = 1'b0; bus.LE = 1'b1; bus.BR_TAKEN = 1'b0; bus.TA = '0;
    @(posedge Clk); #1;

    for (int i = 0; i < vt.size(); i++) begin
      Reset = vt[i].rst; bus.LE = vt[i].le; bus.BR_TAKEN = vt[i].br; bus.TA = vt[i].ta;
      #1;
      chk($sformatf("v%0d_if_le", i), 32'(bus.IF_LE), 32'(vt[i].if_le));
      @(posedge Clk); #1;
      post_checks($sformatf("v%0d", i), vt[i].pc, vt[i].npc, vt[i].pend, vt[i].mis);
    end

    for (int c = 0; c < 3000; c++) begin
      logic        r, le, br;
      logic [31:0] ta;
      r  = (c == 0 || $urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      le = ($urandom_range(0, 99) < 65);
      br = ($urandom_range(0, 99) < 30);
      ta = $urandom;
      if ($urandom_range(0, 7) != 0) ta[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) ta = 32'hFFFF_FFF0 | (ta & 32'hF);
      Reset = r; bus.LE = le; bus.BR_TAKEN = br; bus.TA = ta;
      #1;
      if (c != 0) chk("rnd_if_le", 32'(bus.IF_LE), 32'(le && !m_boot));
      model_edge(r, le, br, ta);
      @(posedge Clk); #1;
      post_checks("rnd", m_pc, m_npc, m_q.size() != 0, m_mis);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register and owns the PC and nPC registers. Each cycle it drives the instruction-memory address, and it applies stalls from the hazard unit. It redirects to branch/jump targets resolved in ID, keeping MIPS delay-slot semantics. Its outputs are PC, a load enable for IF/ID, and status flags.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset (word aligned)
- IMEM_AW, 9, instruction-memory byte-address width

Ports:
- Clk  in  1  pipeline clock, all state on rising edge
- Reset  in  1  synchronous, active-low reset (Reset==0 at a rising edge resets)
- LE  in  1  advance enable from hazard unit; 0 = stall IF
- BR_TAKEN  in  1  branch/jump in ID resolved taken this cycle
- TA  in  32  target address for BR_TAKEN
- PC  out  32  address of instruction being fetched; feeds IF/ID PC input
- NPC  out  32  registered PC+4
- IMEM_ADDR  out  IMEM_AW  PC[IMEM_AW-1:0], combinational from PC
- IF_LE  out  1  load enable for IF/ID register
- PEND  out  1  a taken target is latched and awaiting release of a stall
- TA_MISALIGN  out  1  sticky: a consumed target had TA[1:0]!=0

## Operation
- Reset values: PC=RESET_PC, NPC=RESET_PC+4, state BOOT, pending target=0, PEND=0, TA_MISALIGN=0, IF_LE=0.
- The state machine has three states: BOOT, RUN, PEND.
- BOOT: lasts exactly one cycle after reset is released.
  - PC and NPC hold.
  - IF_LE=0; BR_TAKEN is ignored.
  - Goes to RUN unconditionally.
- RUN with LE=1, BR_TAKEN=1: PC<=T, NPC<=T+4, where T={TA[31:2],2'b00}.
- RUN with LE=1, BR_TAKEN=0: PC<=NPC, NPC<=NPC+4.
- RUN with LE=0, BR_TAKEN=1: pending target<=T and go to PEND. PC and NPC hold.
- RUN with LE=0, BR_TAKEN=0: hold everything.
- PEND with LE=0: PC and NPC hold. If BR_TAKEN=1, the pending target is overwritten with the new T (latest wins).
- PEND with LE=1:
  - If BR_TAKEN=1, T is taken from TA; otherwise T is the pending target.
  - PC<=T, NPC<=T+4, then go to RUN.
- Delay slot: the instruction at PC while BR_TAKEN is asserted is the delay slot. It is still latched into IF/ID, with no flush. Redirect takes effect on the next PC update.
- IF_LE = LE when state is RUN or PEND; IF_LE=0 in BOOT.
- PEND output = (state==PEND).
- TA_MISALIGN: set whenever a target is captured or consumed with TA[1:0]!=0. It is cleared only by reset.
- Arithmetic: all PC math is 32-bit modulo 2^32. 0xFFFF_FFFC+4 = 0x0000_0000. IMEM_ADDR wraps naturally at 2^IMEM_AW.
- Reset asserted in any state, including PEND, overrides all other inputs that cycle and discards the pending target.

## Timing
- PC, NPC, state, PEND and TA_MISALIGN are registered, with 1-cycle update latency.
- IMEM_ADDR and IF_LE are combinational from registered state and LE. There is no path from TA or BR_TAKEN to IMEM_ADDR within the same cycle.
- Redirect latency is one cycle: BR_TAKEN&LE at edge n gives PC==T after edge n.
- A stall with a pending target adds no extra cycle: the first edge with LE=1 loads T.
- After reset is released, the first fetch at RESET_PC is latched by IF/ID at the end of the RUN cycle that follows BOOT.

## Structure
- A shared package, mips_pkg, holds:
  - the state enum (BOOT, RUN, PEND);
  - the constants WORD_BYTES=4 and RESET_PC_DEFAULT;
  - the function align_word(x) = {x[31:2],2'b00}, reused by the EX/MEM address logic.
- One natural sub-module: fetch_fsm (state register plus next-state and pending-target capture). The PC/NPC datapath stays in the top module.

## Test plan
- Reset low 2 cycles, then high with LE=1 → PC=0 during reset and BOOT, and IF_LE=0 in BOOT. Then IF_LE=1 and PC sequence 0, 4, 8, 0xC; NPC always PC+4.
- Branch in ID: PC=0x0C, BR_TAKEN=1, TA=0x40, LE=1 → IF/ID latches the delay slot at 0x0C. Next cycle PC=0x40, NPC=0x44.
- Stall: PC=0x10, LE=0 for 3 cycles → PC, NPC and IMEM_ADDR hold and IF_LE=0. LE=1 → PC=0x14.
- Stall with branch: LE=0 and a one-cycle BR_TAKEN pulse with TA=0x80 → PEND=1 while LE stays 0 for 2 more cycles, and PC holds. LE=1 with BR_TAKEN=0 → PC=0x80, PEND=0.
- Misaligned target: TA=0x103 taken → PC=0x100 and TA_MISALIGN=1. The flag stays 1 through later branches until Reset=0.
- Wrap and reset: PC=0xFFFF_FFFC with LE=1 → PC=0, and IMEM_ADDR goes 0x1FC→0x000. Reset=0 while in PEND → PC=RESET_PC, PEND=0, and after release the pending target is not applied.
